// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shifter_pkg
// Purpose  : Shared types and constants for the iterative shifter.
// Revision : 1.0
// ============================================================================
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_LOGIC = 2'b00,
    SH_ARITH = 2'b01,
    SH_ROT   = 2'b10
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shifter_state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : One-position combinational shift/rotate stage.
// Revision : 1.0
// ============================================================================
module shift_step
  import shifter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] data,
  input  logic         dir,
  input  logic [1:0]   mode,
  output logic [N-1:0] data_out,
  output logic         bit_out
);

  logic w_rot;
  logic w_arith;
  logic w_msb_fill;
  logic w_lsb_fill;

  // Reserved mode 2'b11 decodes as neither rotate nor arithmetic, i.e. logical.
  assign w_rot      = (mode == SH_ROT);
  assign w_arith    = (mode == SH_ARITH);
  assign w_msb_fill = w_rot ? data[0] : (w_arith ? data[N-1] : 1'b0);
  assign w_lsb_fill = w_rot ? data[N-1] : 1'b0;

  always_comb begin
    data_out = '0;
    bit_out  = 1'b0;
    if (dir == DIR_LEFT) begin
      data_out = {data[N-2:0], w_lsb_fill};
      bit_out  = data[N-1];
    end else begin
      data_out = {w_msb_fill, data[N-1:1]};
      bit_out  = data[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/shifter_nposiciones.sv
`default_nettype none
// ============================================================================
// Module   : shifter_nposiciones
// Purpose  : Iterative N-bit shifter/rotator, one position per clock.
// Revision : 1.0
// ============================================================================
module shifter_nposiciones
  import shifter_pkg::*;
#(
  parameter  int N  = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  a_in,
  input  logic [AW-1:0] amt,
  input  logic          dir,
  input  logic [1:0]    mode,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  a_out,
  output logic          carry,
  output logic          zero
);

  localparam logic [AW:0] c_amt_max = (AW+1)'(N-1);

  shifter_state_t r_state;
  logic [N-1:0]   r_data;
  logic [AW-1:0]  r_count;
  logic           r_carry;
  logic           r_dir;
  logic [1:0]     r_mode;

  logic [N-1:0]   w_step_data;
  logic           w_step_bit;
  logic [AW-1:0]  w_amt_sat;

  // Only reachable when N is not a power of two.
  assign w_amt_sat = ({1'b0, amt} > c_amt_max) ? c_amt_max[AW-1:0] : amt;

  shift_step #(.N(N)) u_step (
    .data     (r_data),
    .dir      (r_dir),
    .mode     (r_mode),
    .data_out (w_step_data),
    .bit_out  (w_step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_carry <= 1'b0;
      r_dir   <= DIR_RIGHT;
      r_mode  <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_data  <= a_in;
            r_count <= w_amt_sat;
            r_dir   <= dir;
            r_mode  <= mode;
            r_carry <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_count != '0) begin
            r_data  <= w_step_data;
            r_carry <= w_step_bit;
            r_count <= r_count - AW'(1);
          end else begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready = (r_state == IDLE);
  assign busy  = (r_state == SHIFT);
  assign done  = (r_state == DONE);
  assign a_out = r_data;
  assign carry = r_carry;
  assign zero  = (r_data == '0);

endmodule
`default_nettype wire

// File: doc/shifter_nposiciones.md
Name: shifter_nposiciones

Overview:
Iterative, parametrised barrel-shifter replacement that shifts or rotates an N-bit operand by 0..N-1 positions, left or right, one position per clock. It supports logical, arithmetic and rotate modes, and uses a start/ready/done handshake. It reports carry-out (the last bit shifted out) and a zero flag. It sits between the operand registers and the ALU result mux in the lab datapath, and reuses a single one-position combinational stage inside a sequential loop.

Parameters:
N, 8, operand width in bits (N >= 2)
AW, $clog2(N), width of shift-amount port (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when ready=1
a_in  in  N  operand, captured on accepted start
amt  in  AW  shift amount 0..N-1, captured on accepted start
dir  in  1  1=left, 0=right, captured on accepted start
mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
ready  out  1  block idle, start will be accepted
busy  out  1  operation in progress
done  out  1  one-cycle pulse, result valid
a_out  out  N  result, held until next accepted start
carry  out  1  last bit shifted out (rotate: last bit wrapped); 0 if amt=0
zero  out  1  a_out == 0

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-operation): state=IDLE, ready=1, busy=0, done=0, a_out=0, carry=0, zero=1, internal count=0. Any in-flight operation is discarded.
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE: ready=1. If start=1 at edge E0: capture a_in into the data register, amt into count, and dir/mode. Clear carry. Go to SHIFT.
- SHIFT: busy=1, ready=0.
  - At each edge with count != 0: data <= one-position shift of data, carry <= bit leaving the word, count <= count-1.
  - At the edge with count == 0: go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, ready=0. Then go to IDLE.
- Latency: done is high in the cycle following edge E0+amt+1. With amt=0, that is the cycle after E0+1.
- Outputs: a_out mirrors the data register. It changes only during SHIFT and is stable from DONE until the next accepted start. zero and carry are valid whenever done=1 and remain held afterwards.
- start is ignored while in SHIFT or DONE. It is not queued.
- Shift semantics per step, right (dir=0):
  - logical: MSB <= 0.
  - arithmetic: MSB <= MSB, i.e. sign fill.
  - rotate: MSB <= old LSB.
  - carry <= old LSB in all three modes.
- Shift semantics per step, left (dir=1):
  - LSB <= 0 for logical and arithmetic; LSB <= old MSB for rotate.
  - carry <= old MSB.
- amt is unsigned. Values >= N cannot occur when N is a power of two. For other N, amt is saturated to N-1 at capture.

Decomposition:
- Package shifter_pkg: shift_mode_t enum (SH_LOGIC, SH_ARITH, SH_ROT), shifter_state_t enum (IDLE, SHIFT, DONE), DIR_LEFT/DIR_RIGHT constants.
- Sub-module shift_step #(N): purely combinational one-position stage. Inputs are data, dir and mode; outputs are shifted data and bit_out. It is instantiated once and used by the FSM every SHIFT cycle.

Test Plan:
- N=8, logical right, a_in=8'hB4, amt=3 -> a_out=8'h16, carry=1, zero=0. done pulses in the cycle after E0+4; busy high for 4 cycles.
- Arithmetic right, a_in=8'h90, amt=2 -> a_out=8'hE4, carry=0. The same operand with logical mode gives 8'h24.
- Rotate left, a_in=8'h81, amt=1 -> a_out=8'h03, carry=1. Logical left, a_in=8'hFF, amt=7 -> a_out=8'h80, carry=1.
- amt=0, a_in=8'h00 -> a_out=8'h00, carry=0, zero=1, done in the cycle after E0+1. Logical right, a_in=8'h01, amt=1 -> a_out=8'h00, zero=1, carry=1.
- Second start asserted while busy with a different a_in -> ignored; the first result is delivered unchanged, and ready returns to 1 only after done.
- rst_n pulled low mid-SHIFT (asynchronous, between edges) -> a_out=0, busy=0, done=0, ready=1 immediately. A fresh start after release completes normally.
